// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, 16x-oversampled start/data/stop
// detection, single-cycle valid / frame_err pulses and break-condition hold-off.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITN_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bitn_q, bitn_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   rx_meta_q, rx_s_q;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end

        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!rx_s_q) begin
              state_d = S_DATA;
              bitn_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_END) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            bitn_d  = bitn_q + BW'(1);
            if (bitn_q == BITN_LAST) state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        // A held-low line must return high before another start bit is accepted.
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive path driven by the 16x-oversampling tick from the baud-rate generator. Synchronises the asynchronous `rx` line and detects a start bit. Samples each data bit at its centre, LSB first, and checks the stop bit. Presents each received byte with a single-clock `valid` pulse, or flags a framing error. Sits between the board RX pin and the command/FIFO logic, sharing the baud generator's `tick` with the transmit path.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5–8).
- `OVERSAMPLE`, default 16: `tick` pulses per bit period; must be even and ≥ 4.

- `clk`  input  1  system clock; all state is on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `tick`  input  1  one-`clk` strobe, OVERSAMPLE per bit time, from the baud generator.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `data`  output  DATA_BITS  last received word; holds until the next frame completes.
- `valid`  output  1  one-`clk` pulse: `data` was just updated with a good frame.
- `frame_err`  output  1  one-`clk` pulse: stop bit sampled low.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`), with reset value 1. All decisions below use `rx_s`.
- Internal registers:
  - `cnt`: tick counter, width clog2(OVERSAMPLE).
  - `bitn`: data-bit index, width clog2(DATA_BITS+1).
  - `shreg`: shift register, DATA_BITS wide.
- State and counter updates happen only in cycles with `tick`=1. Cycles without `tick` hold all state, except that the `valid` and `frame_err` pulses clear.
- **IDLE**
  - On tick with `rx_s`=0: go to START with `cnt`=0.
  - Otherwise stay in IDLE.
- **START**
  - On each tick, `cnt`++.
  - At the tick where `cnt`==OVERSAMPLE/2−1 (mid start bit):
    - If `rx_s`=0: go to DATA with `cnt`=0 and `bitn`=0.
    - If `rx_s`=1: false start (glitch); return to IDLE with no output pulse.
- **DATA**
  - On each tick, `cnt`++.
  - At `cnt`==OVERSAMPLE−1 (bit centre):
    - Shift `rx_s` into the MSB of `shreg` (right shift, so the first bit lands in the LSB).
    - Set `cnt`=0 and `bitn`++.
    - When `bitn` reaches DATA_BITS: go to STOP.
- **STOP**
  - At `cnt`==OVERSAMPLE−1:
    - If `rx_s`=1: load `data`←`shreg`, pulse `valid`, go to IDLE.
    - If `rx_s`=0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- **BREAK**
  - Stay until a tick with `rx_s`=1, then go to IDLE.
  - This prevents a held-low line (break condition) from retriggering continuous frames.
- Counter rules:
  - `cnt` never wraps. It is reset explicitly at each compare point.
  - `bitn` counts to DATA_BITS exactly.
- `tick` asserted on consecutive clocks is legal; each counts once.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, `cnt`=0, `bitn`=0, `shreg`=0, synchroniser flops=1.
- `rst_n` low mid-frame aborts immediately to IDLE with the reset values. No pulse is issued for the aborted frame.
- Input latency: a falling edge on `rx` is visible to the FSM 2 `clk` after it is captured.
- Output pulses:
  - `valid` and `frame_err` are registered and go high the `clk` after the stop-bit sampling tick.
  - Each is high for exactly one `clk`, regardless of tick spacing.
  - They are mutually exclusive.
- `data` changes in the same cycle that `valid` rises, and is stable until the next `valid`.
- Frame timing: start detection to the stop-bit sample is OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks. With defaults that is 152 ticks.
- Back-to-back frames:
  - IDLE is re-entered at mid stop bit.
  - A start bit arriving at the nominal next bit edge is detected normally.
- `busy`:
  - Rises with the START entry.
  - Falls on the IDLE entry after STOP, or after BREAK exits.

## Test plan
- **Single byte:** bench `tick` every 4 `clk`. Send 0x55 with a proper stop bit. Expect one `valid` pulse, `data`=0x55, `frame_err` never high, and `busy` low afterwards.
- **Back-to-back:** send 0x00, 0xFF, 0xA3 with no idle gap. Expect exactly three `valid` pulses with `data` 0x00, 0xFF, 0xA3 in order.
- **Glitch:** drive `rx` low for 3 ticks, then high. Expect no `valid`, no `frame_err`, and `busy` back to 0 within OVERSAMPLE/2 ticks.
- **Framing error:**
  - Send 0xA3 with the stop bit low, then hold `rx` low for 40 ticks.
  - Expect a single `frame_err` pulse, `data` unchanged from its prior value, and `busy` high until `rx` returns high.
  - Then send 0x3C and expect `valid` with `data`=0x3C.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 of 0x96. Expect all outputs at reset values asynchronously. After release, send 0x96 and expect a clean `valid` with `data`=0x96.
- **Tick gating:** hold `tick`=0 for 100 `clk` mid-frame. Expect no state, `cnt` or output change. Reception then completes correctly when ticks resume.
